// File: rtl/matrix_scan_driver.sv
// Self-timed LED matrix scanner: column ring, dwell/blanking timing and a
// double-buffered frame store loaded through a valid/ready handshake.
module matrix_scan_driver #(
  parameter int COLS           = 5,
  parameter int ROWS           = 7,
  parameter int DWELL          = 1000,
  parameter int BLANK          = 8,
  parameter int ROW_ACTIVE_LOW = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 load_valid,
  output logic                 load_ready,
  input  logic [COLS*ROWS-1:0] load_frame,
  output logic [COLS-1:0]      m_col,
  output logic [ROWS-1:0]      m_row,
  output logic                 frame_done
);

  localparam int MAX_DB     = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int MAX_V      = (MAX_DB > COLS) ? MAX_DB : COLS;
  localparam int CNT_W      = $clog2(MAX_V + 1);
  localparam int BLANK_LAST = (BLANK > 0) ? BLANK - 1 : 0;
  localparam int DWELL_LAST = DWELL - 1;
  localparam logic [ROWS-1:0] ROW_OFF = (ROW_ACTIVE_LOW != 0) ? '1 : '0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BLANK,
    ST_SHOW
  } state_t;

  state_t                 state, state_n;
  logic [CNT_W-1:0]       cnt, cnt_n;
  logic [CNT_W-1:0]       col_idx, col_n;
  logic                   frame_end;
  logic [COLS*ROWS-1:0]   active, shadow;
  logic                   shadow_full;
  logic                   showing;
  logic [COLS-1:0]        col_onehot;
  logic [ROWS-1:0]        col_pixels;

  assign load_ready = !shadow_full;
  assign showing    = enable && (state == ST_SHOW);
  assign col_onehot = COLS'(1) << col_idx;
  assign col_pixels = active[int'(col_idx)*ROWS +: ROWS];

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    state_n   = state;
    cnt_n     = cnt;
    col_n     = col_idx;
    frame_end = 1'b0;
    if (!enable) begin
      state_n = ST_IDLE;
      cnt_n   = '0;
      col_n   = '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          state_n = ST_BLANK;
          cnt_n   = '0;
          col_n   = '0;
        end
        ST_BLANK: begin
          // With BLANK=0 the counter is already 0 here, so the state lasts one cycle.
          if (cnt == CNT_W'(BLANK_LAST)) begin
            state_n = ST_SHOW;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        ST_SHOW: begin
          if (cnt == CNT_W'(DWELL_LAST)) begin
            state_n = ST_BLANK;
            cnt_n   = '0;
            if (col_idx == CNT_W'(COLS - 1)) begin
              col_n     = '0;
              frame_end = 1'b1;
            end else begin
              col_n = col_idx + 1'b1;
            end
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      col_idx     <= '0;
      // NOTE: frame buffers are reset too, so a restart shows a dark image and drops any pending frame.
      active      <= '0;
      shadow      <= '0;
      shadow_full <= 1'b0;
      m_col       <= '0;
      m_row       <= ROW_OFF;
      frame_done  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state      <= state_n;
      cnt        <= cnt_n;
      col_idx    <= col_n;
      frame_done <= frame_end;
      m_col      <= showing ? col_onehot : '0;
      m_row      <= showing ? (col_pixels ^ ROW_OFF) : ROW_OFF;
      // Swap only at a frame boundary; a pending shadow blocks new loads until then.
      if (frame_end && shadow_full) begin
        active      <= shadow;
        shadow_full <= 1'b0;
      end else if (load_valid && !shadow_full) begin
        shadow      <= load_frame;
        shadow_full <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_matrix_scan_driver.sv
// Directed bench for matrix_scan_driver (COLS=5, ROWS=7, DWELL=4, BLANK=2),
// with an active-high and an active-low row build driven side by side.
module tb_matrix_scan_driver;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        load_valid = 1'b0;
  logic [34:0] load_frame = '0;
  logic        load_ready, load_ready_n;
  logic [4:0]  m_col, m_col_n;
  logic [6:0]  m_row, m_row_n;
  logic        frame_done, frame_done_n;

  int errors = 0;
  int checks = 0;
  logic mon_en = 1'b0;
  logic acc_q = 1'b0;

  always #5 clk = ~clk;

  matrix_scan_driver #(.COLS(5), .ROWS(7), .DWELL(4), .BLANK(2), .ROW_ACTIVE_LOW(0)) dut (
    .clk(clk), .reset(reset), .enable(enable), .load_valid(load_valid),
    .load_ready(load_ready), .load_frame(load_frame), .m_col(m_col),
    .m_row(m_row), .frame_done(frame_done)
  );

  matrix_scan_driver #(.COLS(5), .ROWS(7), .DWELL(4), .BLANK(2), .ROW_ACTIVE_LOW(1)) dut_n (
    .clk(clk), .reset(reset), .enable(enable), .load_valid(load_valid),
    .load_ready(load_ready_n), .load_frame(load_frame), .m_col(m_col_n),
    .m_row(m_row_n), .frame_done(frame_done_n)
  );

  // Cycle n counts sampling points after the edge that first sees enable=1.
  // Column c of each 30-cycle frame is lit for samples 3+6c .. 6+6c.
  function automatic logic [24:0] exp_vec(int n, logic [34:0] f0, logic [34:0] f1,
                                          logic [34:0] f2, logic [34:0] f3);
    logic [4:0]  col;
    logic [6:0]  row;
    logic        done;
    logic [34:0] f;
    int q, fi;
    col = '0; row = '0; done = 1'b0;
    if (n >= 3) begin
      q  = (n - 3) % 30;
      fi = (n - 3) / 30;
      f  = (fi == 0) ? f0 : (fi == 1) ? f1 : (fi == 2) ? f2 : f3;
      if (q % 6 < 4) begin
        col = 5'(1) << (q / 6);
        row = f[(q / 6) * 7 +: 7];
      end
      done = (q == 27);
    end
    return {col, row, done, col, row ^ 7'h7F};
  endfunction

  function automatic logic [34:0] pat(int k);
    return {5{7'(k + 1)}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; enable = 1'b0; load_valid = 1'b0; load_frame = '0;
    tick(); tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic preload(input logic [34:0] f);
    load_valid = 1'b1; load_frame = f;
    tick();
    load_valid = 1'b0;
    checks++;
    if (load_ready !== 1'b0) begin
      errors++; $display("FAIL preload_ready got=%b exp=0", load_ready);
    end
  endtask

  always @(posedge clk) acc_q <= load_valid && load_ready && !reset;

  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if (!$onehot0(m_col) || !$onehot0(m_col_n)) begin
        errors++; $display("FAIL col_onehot got=%b/%b exp=at most one bit", m_col, m_col_n);
      end
      if (frame_done) begin
        checks++;
        if (acc_q) begin
          errors++; $display("FAIL load_at_swap got=accept exp=no accept");
        end
      end
    end
  end

  task automatic test_reset();
    do_reset();
    mon_en = 1'b1;
    for (int n = 0; n < 20; n++) begin
      tick();
      checks++;
      if ({m_col, m_row, frame_done, m_col_n, m_row_n, load_ready, load_ready_n}
          !== {5'b0, 7'b0, 1'b0, 5'b0, 7'h7F, 1'b1, 1'b1}) begin
        errors++;
        $display("FAIL reset_idle n=%0d got col=%b row=%b done=%b row_n=%b rdy=%b exp col=0 row=0 done=0 row_n=1111111 rdy=1",
                 n, m_col, m_row, frame_done, m_row_n, load_ready);
      end
    end
  endtask

  task automatic test_scan();
    logic [24:0] e;
    do_reset();
    preload(35'h7_FFFF_FFFF);
    enable = 1'b1;
    for (int n = 0; n <= 62; n++) begin
      tick();
      e = exp_vec(n, '0, 35'h7_FFFF_FFFF, 35'h7_FFFF_FFFF, 35'h7_FFFF_FFFF);
      checks++;
      if ({m_col, m_row, frame_done, m_col_n, m_row_n} !== e) begin
        errors++; $display("FAIL scan n=%0d got=%h exp=%h", n,
                           {m_col, m_row, frame_done, m_col_n, m_row_n}, e);
      end
      checks++;
      if (load_ready !== 1'(n >= 30)) begin
        errors++; $display("FAIL scan_ready n=%0d got=%b exp=%b", n, load_ready, n >= 30);
      end
    end
  endtask

  task automatic test_pixel();
    logic [24:0] e;
    logic [34:0] p;
    p = 35'(1) << (2 * 7 + 3);
    do_reset();
    preload(p);
    enable = 1'b1;
    for (int n = 0; n <= 62; n++) begin
      tick();
      e = exp_vec(n, '0, p, p, p);
      checks++;
      if ({m_col, m_row, frame_done, m_col_n, m_row_n} !== e) begin
        errors++; $display("FAIL pixel n=%0d got col=%b row=%b row_n=%b exp=%h", n,
                           m_col, m_row, m_row_n, e);
      end
    end
  endtask

  task automatic test_swap();
    logic [24:0] e;
    logic [34:0] a, b;
    logic        r;
    a = 35'h1_2345_6789;
    b = 35'h6_5432_1FED;
    do_reset();
    preload(a);
    enable = 1'b1;
    for (int n = 0; n <= 70; n++) begin
      tick();
      e = exp_vec(n, '0, a, b, b);
      r = (n >= 30 && n <= 40) || n >= 60;
      checks++;
      if ({m_col, m_row, frame_done, m_col_n, m_row_n} !== e) begin
        errors++; $display("FAIL swap n=%0d got=%h exp=%h", n,
                           {m_col, m_row, frame_done, m_col_n, m_row_n}, e);
      end
      checks++;
      if (load_ready !== r) begin
        errors++; $display("FAIL swap_ready n=%0d got=%b exp=%b", n, load_ready, r);
      end
      if (n == 40) begin load_valid = 1'b1; load_frame = b; end
      if (n == 41) load_valid = 1'b0;
    end
  endtask

  task automatic test_back_to_back();
    logic [24:0] e;
    logic        r;
    do_reset();
    load_valid = 1'b1;
    load_frame = pat(0);
    enable = 1'b1;
    for (int n = 0; n <= 95; n++) begin
      tick();
      e = exp_vec(n, '0, pat(0), pat(31), pat(61));
      r = (n > 0) && (n % 30 == 0);
      checks++;
      if ({m_col, m_row, frame_done, m_col_n, m_row_n} !== e) begin
        errors++; $display("FAIL backpressure n=%0d got=%h exp=%h", n,
                           {m_col, m_row, frame_done, m_col_n, m_row_n}, e);
      end
      checks++;
      if (load_ready !== r) begin
        errors++; $display("FAIL bp_ready n=%0d got=%b exp=%b", n, load_ready, r);
      end
      load_frame = pat(n + 1);
    end
    load_valid = 1'b0;
  endtask

  task automatic test_disruption();
    logic [24:0] e, off;
    off = exp_vec(0, '0, '0, '0, '0);
    do_reset();
    preload(35'h2_AAAA_5555);
    enable = 1'b1;
    for (int n = 0; n <= 22; n++) begin
      tick();
      e = exp_vec(n, '0, '0, '0, '0);
      checks++;
      if ({m_col, m_row, frame_done, m_col_n, m_row_n} !== e) begin
        errors++; $display("FAIL pre_disable n=%0d got=%h exp=%h", n,
                           {m_col, m_row, frame_done, m_col_n, m_row_n}, e);
      end
    end
    enable = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      checks++;
      if ({m_col, m_row, frame_done, m_col_n, m_row_n, load_ready} !== {off, 1'b0}) begin
        errors++; $display("FAIL disabled k=%0d got=%h exp=%h", k,
                           {m_col, m_row, frame_done, m_col_n, m_row_n, load_ready}, {off, 1'b0});
      end
    end
    enable = 1'b1;
    for (int n = 0; n <= 4; n++) begin
      tick();
      e = exp_vec(n, '0, '0, '0, '0);
      checks++;
      if ({m_col, m_row, frame_done, m_col_n, m_row_n} !== e) begin
        errors++; $display("FAIL reenable n=%0d got=%h exp=%h", n,
                           {m_col, m_row, frame_done, m_col_n, m_row_n}, e);
      end
    end
    reset = 1'b1;
    tick();
    checks++;
    if ({m_col, m_row, frame_done, m_col_n, m_row_n, load_ready} !== {off, 1'b1}) begin
      errors++; $display("FAIL mid_reset got=%h exp=%h",
                         {m_col, m_row, frame_done, m_col_n, m_row_n, load_ready}, {off, 1'b1});
    end
    reset = 1'b0;
    for (int n = 0; n <= 36; n++) begin
      tick();
      e = exp_vec(n, '0, '0, '0, '0);
      checks++;
      if ({m_col, m_row, frame_done, m_col_n, m_row_n, load_ready} !== {e, 1'b1}) begin
        errors++; $display("FAIL post_reset n=%0d got=%h exp=%h", n,
                           {m_col, m_row, frame_done, m_col_n, m_row_n, load_ready}, {e, 1'b1});
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_pixel();
    test_swap();
    test_back_to_back();
    test_disruption();
    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
